// File: rtl/instr_uop_sequencer.sv
// instr_uop_sequencer: expands instruction words into registered micro-ops.
// Opcode map: 0000 ADDRR, 0001 ADDRA, 0010 SUBRR, 0011 MULRR, 0100 MULRA,
// 0101 XOR, 0110 INV, 0111 AND, 1000 NOP, 1010 OR, 1011 LD, 1100 ST,
// 1101 JMP; 1001/1110/1111 reserved.
module instr_uop_sequencer #(
    parameter int REG_AW   = 2,
    parameter int IMM_W    = 8,
    parameter int MUL_LAT  = 3,
    parameter int RES_TRAP = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4+2*REG_AW+IMM_W-1:0] instr,
    output logic                        uop_valid,
    input  logic                        uop_ready,
    output logic [2:0]                  uop_alu_sel,
    output logic [REG_AW-1:0]           uop_rd,
    output logic [REG_AW-1:0]           uop_rs,
    output logic [IMM_W-1:0]            uop_imm,
    output logic                        uop_use_imm,
    output logic                        uop_reg_we,
    output logic                        uop_mem_re,
    output logic                        uop_mem_we,
    output logic                        uop_jump,
    output logic                        uop_mul_step,
    output logic                        uop_illegal,
    output logic                        uop_last,
    output logic                        illegal_seen
);
    localparam int INSTR_W = 4 + 2*REG_AW + IMM_W;

    localparam logic [3:0] OP_ADDRR = 4'b0000, OP_ADDRA = 4'b0001,
                           OP_SUBRR = 4'b0010, OP_MULRR = 4'b0011,
                           OP_MULRA = 4'b0100, OP_XOR   = 4'b0101,
                           OP_INV   = 4'b0110, OP_AND   = 4'b0111,
                           OP_NOP   = 4'b1000, OP_RES0  = 4'b1001,
                           OP_OR    = 4'b1010, OP_LD    = 4'b1011,
                           OP_ST    = 4'b1100, OP_JMP   = 4'b1101,
                           OP_RES1  = 4'b1110, OP_RES2  = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_MUL = 3'd2,
                           ALU_XOR = 3'd3, ALU_INV = 3'd4, ALU_AND = 3'd5,
                           ALU_OR  = 3'd6, ALU_PASS = 3'd7;

    typedef struct packed {
        logic [2:0] alu_sel;
        logic       use_imm;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       jump;
        logic       mul_step;
        logic       illegal;
        logic       last;
    } ctl_t;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state, nxt_state;
    logic [3:0]          seq_idx, nxt_idx;
    logic [3:0]          op_q, nxt_op;
    logic [REG_AW-1:0]   rd_q, rs_q, nxt_rd, nxt_rs;
    logic [IMM_W-1:0]    imm_q, nxt_imm;
    ctl_t                ctl_q, nxt_ctl;
    logic                accept;

    wire [3:0]        op_in  = instr[INSTR_W-1 -: 4];
    wire [REG_AW-1:0] rd_in  = instr[INSTR_W-5 -: REG_AW];
    wire [REG_AW-1:0] rs_in  = instr[IMM_W +: REG_AW];
    wire [IMM_W-1:0]  imm_in = instr[IMM_W-1:0];

    // Number of uops an opcode expands into; zero means the instruction is dropped.
    function automatic logic [3:0] uop_count(input logic [3:0] op);
        case (op)
            OP_MULRR, OP_MULRA:         return 4'(MUL_LAT);
            OP_LD:                      return 4'd2;
            OP_NOP:                     return 4'd0;
            OP_RES0, OP_RES1, OP_RES2:  return (RES_TRAP != 0) ? 4'd1 : 4'd0;
            default:                    return 4'd1;
        endcase
    endfunction

    // Control word for uop number idx of opcode op.
    function automatic ctl_t decode(input logic [3:0] op, input logic [3:0] idx);
        ctl_t c;
        logic last;
        c    = '0;
        last = (idx == uop_count(op) - 4'd1);
        case (op)
            OP_ADDRR: begin c.alu_sel = ALU_ADD; c.reg_we = 1'b1; end
            OP_ADDRA: begin c.alu_sel = ALU_ADD; c.reg_we = 1'b1; c.use_imm = 1'b1; end
            OP_SUBRR: begin c.alu_sel = ALU_SUB; c.reg_we = 1'b1; end
            OP_XOR:   begin c.alu_sel = ALU_XOR; c.reg_we = 1'b1; end
            OP_INV:   begin c.alu_sel = ALU_INV; c.reg_we = 1'b1; end
            OP_AND:   begin c.alu_sel = ALU_AND; c.reg_we = 1'b1; end
            OP_OR:    begin c.alu_sel = ALU_OR;  c.reg_we = 1'b1; end
            OP_MULRR, OP_MULRA: begin
                c.alu_sel  = ALU_MUL;
                c.mul_step = 1'b1;
                c.use_imm  = (op == OP_MULRA);
                c.reg_we   = last;
            end
            OP_LD: begin
                if (idx == 4'd0) begin
                    c.alu_sel = ALU_PASS;
                    c.mem_re  = 1'b1;
                end else begin
                    c.reg_we  = 1'b1;
                end
            end
            OP_ST:    begin c.alu_sel = ALU_PASS; c.mem_we = 1'b1; end
            OP_JMP:   c.jump = 1'b1;
            OP_NOP:   c = '0;
            default:  c.illegal = (RES_TRAP != 0);
        endcase
        c.last = last;
        return c;
    endfunction

    assign uop_valid = (state == EMIT);
    assign in_ready  = !rst && (state == IDLE || (uop_valid && ctl_q.last && uop_ready));
    assign accept    = in_valid && in_ready;

    // Next-state: a new accept wins over advancing, so a last-uop consume and
    // a fresh instruction overlap without a bubble.
    always_comb begin
        nxt_state = state;
        nxt_idx   = seq_idx;
        nxt_op    = op_q;
        nxt_rd    = rd_q;
        nxt_rs    = rs_q;
        nxt_imm   = imm_q;
        nxt_ctl   = ctl_q;
        if (accept) begin
            nxt_op  = op_in;
            nxt_rd  = rd_in;
            nxt_rs  = rs_in;
            nxt_imm = imm_in;
            nxt_idx = 4'd0;
            if (uop_count(op_in) == 4'd0) begin
                nxt_state = IDLE;
                nxt_ctl   = '0;
            end else begin
                nxt_state = EMIT;
                nxt_ctl   = decode(op_in, 4'd0);
            end
        end else if (state == EMIT && uop_ready) begin
            if (!ctl_q.last) begin
                nxt_idx = seq_idx + 4'd1;
                nxt_ctl = decode(op_q, seq_idx + 4'd1);
            end else begin
                nxt_state = IDLE;
                nxt_ctl   = '0;
            end
        end
    end

    // State and uop register; illegal_seen rises together with the trap uop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            seq_idx      <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            rs_q         <= '0;
            imm_q        <= '0;
            ctl_q        <= '0;
            illegal_seen <= 1'b0;
        end else begin
            state   <= nxt_state;
            seq_idx <= nxt_idx;
            op_q    <= nxt_op;
            rd_q    <= nxt_rd;
            rs_q    <= nxt_rs;
            imm_q   <= nxt_imm;
            ctl_q   <= nxt_ctl;
            if (nxt_state == EMIT && nxt_ctl.illegal)
                illegal_seen <= 1'b1;
        end
    end

    assign uop_alu_sel  = ctl_q.alu_sel;
    assign uop_rd       = rd_q;
    assign uop_rs       = rs_q;
    assign uop_imm      = imm_q;
    assign uop_use_imm  = ctl_q.use_imm;
    assign uop_reg_we   = ctl_q.reg_we;
    assign uop_mem_re   = ctl_q.mem_re;
    assign uop_mem_we   = ctl_q.mem_we;
    assign uop_jump     = ctl_q.jump;
    assign uop_mul_step = ctl_q.mul_step;
    assign uop_illegal  = ctl_q.illegal;
    assign uop_last     = ctl_q.last;
endmodule

// File: tb/tb_instr_uop_sequencer.sv
// Scoreboard bench: expected uops are queued at accept and compared as consumed.
module tb_instr_uop_sequencer;
    localparam int MUL_LAT = 3;

    localparam logic [3:0] ADDRR = 4'b0000, ADDRA = 4'b0001, SUBRR = 4'b0010,
                           MULRR = 4'b0011, MULRA = 4'b0100, XORO  = 4'b0101,
                           INVO  = 4'b0110, ANDO  = 4'b0111, NOP   = 4'b1000,
                           ORO   = 4'b1010, LD    = 4'b1011, ST    = 4'b1100,
                           JMP   = 4'b1101;

    localparam logic [7:0] F_IMM = 8'h80, F_WE = 8'h40, F_RE = 8'h20, F_MW = 8'h10,
                           F_J   = 8'h08, F_MS = 8'h04, F_IL = 8'h02, F_L  = 8'h01;

    logic        clk, rst, in_valid, uop_ready;
    logic [15:0] instr;
    logic        in_ready, uop_valid, uop_use_imm, uop_reg_we, uop_mem_re, uop_mem_we;
    logic        uop_jump, uop_mul_step, uop_illegal, uop_last, illegal_seen;
    logic [2:0]  uop_alu_sel;
    logic [1:0]  uop_rd, uop_rs;
    logic [7:0]  uop_imm;
    logic        b_in_ready, b_uop_valid, b_use_imm, b_reg_we, b_mem_re, b_mem_we;
    logic        b_jump, b_mul_step, b_illegal, b_last, b_illegal_seen;
    logic [2:0]  b_alu_sel;
    logic [1:0]  b_rd, b_rs;
    logic [7:0]  b_imm;

    instr_uop_sequencer #(.REG_AW(2), .IMM_W(8), .MUL_LAT(MUL_LAT), .RES_TRAP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_alu_sel(uop_alu_sel),
        .uop_rd(uop_rd), .uop_rs(uop_rs), .uop_imm(uop_imm), .uop_use_imm(uop_use_imm),
        .uop_reg_we(uop_reg_we), .uop_mem_re(uop_mem_re), .uop_mem_we(uop_mem_we),
        .uop_jump(uop_jump), .uop_mul_step(uop_mul_step), .uop_illegal(uop_illegal),
        .uop_last(uop_last), .illegal_seen(illegal_seen)
    );

    instr_uop_sequencer #(.REG_AW(2), .IMM_W(8), .MUL_LAT(MUL_LAT), .RES_TRAP(0)) dut_nt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr),
        .uop_valid(b_uop_valid), .uop_ready(uop_ready), .uop_alu_sel(b_alu_sel),
        .uop_rd(b_rd), .uop_rs(b_rs), .uop_imm(b_imm), .uop_use_imm(b_use_imm),
        .uop_reg_we(b_reg_we), .uop_mem_re(b_mem_re), .uop_mem_we(b_mem_we),
        .uop_jump(b_jump), .uop_mul_step(b_mul_step), .uop_illegal(b_illegal),
        .uop_last(b_last), .illegal_seen(b_illegal_seen)
    );

    int          nvec = 0, nmis = 0, cyc = 0, last_acc = 0, last_wait = 0;
    logic [22:0] exp_q[$];
    int          pop_log[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] obs_vec();
        return {uop_alu_sel, uop_rd, uop_rs, uop_imm, uop_use_imm, uop_reg_we, uop_mem_re,
                uop_mem_we, uop_jump, uop_mul_step, uop_illegal, uop_last};
    endfunction

    function automatic logic [22:0] mkx(input logic [2:0] alu, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm,
                                        input logic [7:0] fl);
        return {alu, rd, rs, imm, fl};
    endfunction

    // Reference expansion of one instruction into its expected uop sequence.
    task automatic push_exp(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic [7:0] imm);
        case (op)
            ADDRR: exp_q.push_back(mkx(3'd0, rd, rs, imm, F_WE | F_L));
            ADDRA: exp_q.push_back(mkx(3'd0, rd, rs, imm, F_IMM | F_WE | F_L));
            SUBRR: exp_q.push_back(mkx(3'd1, rd, rs, imm, F_WE | F_L));
            XORO:  exp_q.push_back(mkx(3'd3, rd, rs, imm, F_WE | F_L));
            INVO:  exp_q.push_back(mkx(3'd4, rd, rs, imm, F_WE | F_L));
            ANDO:  exp_q.push_back(mkx(3'd5, rd, rs, imm, F_WE | F_L));
            ORO:   exp_q.push_back(mkx(3'd6, rd, rs, imm, F_WE | F_L));
            MULRR, MULRA:
                for (int k = 0; k < MUL_LAT; k++)
                    exp_q.push_back(mkx(3'd2, rd, rs, imm,
                        F_MS | ((op == MULRA) ? F_IMM : 8'h00) |
                        ((k == MUL_LAT-1) ? (F_WE | F_L) : 8'h00)));
            LD: begin
                exp_q.push_back(mkx(3'd7, rd, rs, imm, F_RE));
                exp_q.push_back(mkx(3'd0, rd, rs, imm, F_WE | F_L));
            end
            ST:    exp_q.push_back(mkx(3'd7, rd, rs, imm, F_MW | F_L));
            JMP:   exp_q.push_back(mkx(3'd0, rd, rs, imm, F_J | F_L));
            NOP:   ;
            default: exp_q.push_back(mkx(3'd0, rd, rs, imm, F_IL | F_L));
        endcase
    endtask

    // Drive one instruction; returns at the negedge after it was accepted.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm);
        bit ok = 0;
        instr    = {op, rd, rs, imm};
        in_valid = 1'b1;
        last_wait = 0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (in_ready) begin ok = 1; break; end
            last_wait++;
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        push_exp(op, rd, rs, imm);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #3;
        end
        chk({"drain_", tag}, exp_q.size(), 0);
    endtask

    // Monitor: pop on consume, and verify outputs stay frozen while stalled.
    logic [22:0] held;
    bit          stalled = 0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                chk("hold_valid", uop_valid, 1);
                chk("hold_uop", obs_vec(), held);
            end
            if (uop_valid && uop_ready) begin
                if (exp_q.size() == 0) chk("spurious_uop", uop_valid, 0);
                else begin
                    chk("uop", obs_vec(), exp_q.pop_front());
                    pop_log.push_back(cyc);
                end
            end
            stalled = uop_valid && !uop_ready;
            held    = obs_vec();
        end
    end

    int acc_first;
    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; uop_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_uop_valid", uop_valid, 0);
        chk("rst_uop", obs_vec(), 0);
        chk("rst_seen", illegal_seen, 0);
        chk("rst_nt_all", {b_in_ready, b_uop_valid, b_alu_sel, b_rd, b_rs, b_imm, b_use_imm,
            b_reg_we, b_mem_re, b_mem_we, b_jump, b_mul_step, b_illegal, b_last, b_illegal_seen}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready_post_rst", in_ready, 1);

        // single ADDRR, first uop one cycle after accept
        issue(ADDRR, 2'd1, 2'd2, 8'h00);
        #1;
        chk("add_valid", uop_valid, 1);
        chk("add_alu", uop_alu_sel, 0);
        chk("add_we", uop_reg_we, 1);
        chk("add_last", uop_last, 1);
        drain("add");

        // back-to-back single-uop stream
        pop_log.delete();
        issue(ADDRR, 2'd0, 2'd1, 8'h00); acc_first = last_acc;
        chk("stream_wait0", last_wait, 0);
        issue(SUBRR, 2'd1, 2'd2, 8'h00); chk("stream_wait1", last_wait, 0);
        issue(XORO,  2'd2, 2'd3, 8'h00); chk("stream_wait2", last_wait, 0);
        issue(ANDO,  2'd3, 2'd0, 8'h00); chk("stream_wait3", last_wait, 0);
        drain("stream");
        chk("stream_cnt", pop_log.size(), 4);
        if (pop_log.size() == 4) begin
            chk("stream_first", pop_log[0], acc_first);
            chk("stream_span", pop_log[3] - pop_log[0], 3);
        end

        // MULRA: three uops, in_ready low for two cycles
        issue(MULRA, 2'd2, 2'd1, 8'h05);
        #1 chk("mul_rdy0", in_ready, 0);
        @(negedge clk); #1 chk("mul_rdy1", in_ready, 0);
        @(negedge clk); #1 chk("mul_rdy2", in_ready, 1);
        drain("mul");

        // LD with two stall cycles on uop0
        pop_log.delete();
        uop_ready = 1'b0;
        issue(LD, 2'd3, 2'd1, 8'h20);
        #1 chk("ld_rdy0", in_ready, 0);
        chk("ld_re", uop_mem_re, 1);
        @(negedge clk); #1 chk("ld_rdy1", in_ready, 0);
        @(negedge clk); uop_ready = 1'b1;
        #1 chk("ld_rdy2", in_ready, 0);
        @(negedge clk); #1 chk("ld_wb", uop_reg_we, 1);
        drain("ld");
        chk("ld_cnt", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            chk("ld_pop0", pop_log[0], last_acc + 2);
            chk("ld_pop1", pop_log[1], last_acc + 3);
        end

        // reserved 1111: trap with RES_TRAP=1, silent drop with RES_TRAP=0
        issue(4'b1111, 2'd2, 2'd3, 8'h11);
        #1;
        chk("trap_illegal", uop_illegal, 1);
        chk("trap_seen", illegal_seen, 1);
        chk("nt_valid", b_uop_valid, 0);
        chk("nt_seen", b_illegal_seen, 0);
        drain("trap");
        repeat (2) @(negedge clk);
        #1;
        chk("trap_seen_sticky", illegal_seen, 1);
        chk("nt_seen_later", b_illegal_seen, 0);

        // NOP produces nothing, then JMP
        issue(NOP, 2'd1, 2'd1, 8'hAA);
        #1 chk("nop_no_uop", uop_valid, 0);
        issue(JMP, 2'd0, 2'd0, 8'h3C);
        #1;
        chk("jmp_valid", uop_valid, 1);
        chk("jmp_jump", uop_jump, 1);
        chk("jmp_imm", uop_imm, 8'h3C);
        drain("jmp");
        chk("seen_persist", illegal_seen, 1);

        // reset during second MUL uop
        issue(MULRR, 2'd1, 2'd3, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mrst_valid", uop_valid, 0);
        chk("mrst_seen", illegal_seen, 0);
        rst = 1'b0;
        exp_q.delete();
        #1 chk("mrst_ready", in_ready, 1);
        issue(ADDRA, 2'd2, 2'd0, 8'h7F);
        #1 chk("post_rst_imm", uop_use_imm, 1);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
